// File: rtl/audioport_pkg.sv
// Shared types and constants for the I2S/TDM serial audio port.
// Slot width, config field layout, FSM states, SCK divider table.
package audioport_pkg;

  localparam int I2S_SLOT_W   = 32;

  localparam int CFG_DIV_LSB  = 0;
  localparam int CFG_DIV_W    = 2;
  localparam int CFG_MODE_BIT = 2;
  localparam int CFG_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_TDM = 1'b1
  } mode_e;

  // SCK half-period in clk cycles for each divider select
  function automatic logic [4:0] half_period(
    input logic [CFG_DIV_W-1:0] sel
  );
    logic [4:0] hp;
    unique case (sel)
      2'd0:    hp = 5'd2;
      2'd1:    hp = 5'd4;
      2'd2:    hp = 5'd8;
      default: hp = 5'd16;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk down to SCK while enabled.
// Rise/fall strobes are registered, so they fire the cycle after the edge.
module i2s_sck_gen
  import audioport_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [CFG_DIV_W-1:0] div_i,
  output logic                 sck_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       wrap;

  // half-period counter; disabled means held cleared with SCK low
  always_comb begin
    cnt_d  = '0;
    sck_d  = 1'b0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    wrap   = ({1'b0, cnt_q} == (half_period(div_i) - 5'd1));
    if (en_i) begin
      if (wrap) begin
        sck_d  = ~sck_q;
        rise_d = ~sck_q;
        fall_d = sck_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
        sck_d = sck_q;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2s_tdm_unit.sv
// I2S / TDM serial audio transmitter with a 1-frame holding buffer.
// I2S_TDM_REPEAT_ON_UNDERRUN_EN: underrun resends last frame, else zeros.
module i2s_tdm_unit
  import audioport_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         play_in,
  input  logic                         tick_in,
  input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
  input  logic                         cfg_in,
  input  logic [31:0]                  cfg_reg_in,
  output logic                         req_out,
  output logic                         ws_out,
  output logic                         sck_out,
  output logic                         sdo_out
);

  localparam int AUD_W   = CHANNELS * SAMPLE_W;
  localparam int FRAME_W = CHANNELS * I2S_SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(FRAME_W / 2);

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [AUD_W-1:0]   buf_q, buf_d;
  logic               full_q, full_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic               fend_q, fend_d;
  logic               ws_q, ws_d;
  logic               sdo_q, sdo_d;
  logic               req_q, req_d;

  logic [AUD_W-1:0]   nxt;
  logic [AUD_W-1:0]   fallback;
  logic [FRAME_W-1:0] frame;
  logic               sck_en;
  logic               sck_s, rise_s, fall_s;
  logic               bnd, fs, go_idle;
  logic               tdm;
  logic               unused_cfg;

  assign unused_cfg = ^cfg_reg_in[31:CFG_W];
  assign tdm = (cfg_q[CFG_MODE_BIT] == MODE_TDM);

  // word select for SCK period n of the frame
  function automatic logic ws_of(
    input logic [CNT_W-1:0] n,
    input logic             is_tdm
  );
    return is_tdm ? (n == '0) : (n >= HALF);
  endfunction

`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
  logic [AUD_W-1:0] prev_q, prev_d;
  assign fallback = prev_q;
`else
  assign fallback = '0;
`endif

  // frame data source, left-justified into 32-bit slots, slot 0 first
  always_comb begin
    nxt   = tick_in ? audio_in : (full_q ? buf_q : fallback);
    frame = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      frame[FRAME_W-1-k*I2S_SLOT_W -: SAMPLE_W] =
        nxt[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  // FSM next state, frame sequencing and serial datapath
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    buf_d   = buf_q;
    full_d  = full_q;
    sr_d    = sr_q;
    per_d   = per_q;
    fend_d  = fend_q;
    ws_d    = ws_q;
    sdo_d   = sdo_q;
    req_d   = 1'b0;
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
    prev_d  = prev_q;
`endif
    fs      = 1'b0;
    go_idle = 1'b0;
    bnd     = fall_s && fend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_in) cfg_d = cfg_reg_in[CFG_W-1:0];
        if (play_in) begin
          state_d = ST_RUN;
          fs      = 1'b1;
        end
      end
      ST_RUN: begin
        if (bnd) begin
          if (play_in) fs = 1'b1;
          else         go_idle = 1'b1;
        end else if (!play_in) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bnd) begin
          if (play_in) begin
            fs      = 1'b1;
            state_d = ST_RUN;
          end else begin
            go_idle = 1'b1;
          end
        end else if (play_in) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick_in) begin
      buf_d  = audio_in;
      full_d = 1'b1;
    end

    if (rise_s) fend_d = (per_q == LAST);

    if (fs) begin
      // sdo lags ws by one SCK: period 0 carries the old frame's last bit
      sdo_d  = sr_q[FRAME_W-1];
      sr_d   = frame;
      buf_d  = '0;
      full_d = 1'b0;
      per_d  = '0;
      fend_d = 1'b0;
      ws_d   = ws_of('0, tdm);
      req_d  = 1'b1;
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
      prev_d = nxt;
`endif
    end else if (go_idle) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      per_d   = '0;
      fend_d  = 1'b0;
      ws_d    = 1'b0;
      sdo_d   = 1'b0;
    end else if (fall_s) begin
      sdo_d = sr_q[FRAME_W-1];
      sr_d  = sr_q << 1;
      per_d = per_q + CNT_W'(1);
      ws_d  = ws_of(per_q + CNT_W'(1), tdm);
    end

    sck_en = (state_q != ST_IDLE) && (state_d != ST_IDLE);
  end

  i2s_sck_gen u_sck (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (sck_en),
    .div_i  (cfg_q[CFG_DIV_LSB +: CFG_DIV_W]),
    .sck_o  (sck_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      sr_q    <= '0;
      per_q   <= '0;
      fend_q  <= 1'b0;
      ws_q    <= 1'b0;
      sdo_q   <= 1'b0;
      req_q   <= 1'b0;
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      sr_q    <= sr_d;
      per_q   <= per_d;
      fend_q  <= fend_d;
      ws_q    <= ws_d;
      sdo_q   <= sdo_d;
      req_q   <= req_d;
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign req_out = req_q;
  assign ws_out  = ws_q;
  assign sck_out = sck_s;
  assign sdo_out = sdo_q;

endmodule

// File: tb/tb_i2s_tdm_unit.sv
// Directed bench for i2s_tdm_unit (2 channels, 24-bit samples).
// Frames are captured on SCK rising edges and compared as 64-bit vectors.
module tb_i2s_tdm_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        play_in;
  logic        tick_in;
  logic [47:0] audio_in;
  logic        cfg_in;
  logic [31:0] cfg_reg_in;
  logic        req_out;
  logic        ws_out;
  logic        sck_out;
  logic        sdo_out;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  i2s_tdm_unit #(
    .CHANNELS (2),
    .SAMPLE_W (24)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_in    (play_in),
    .tick_in    (tick_in),
    .audio_in   (audio_in),
    .cfg_in     (cfg_in),
    .cfg_reg_in (cfg_reg_in),
    .req_out    (req_out),
    .ws_out     (ws_out),
    .sck_out    (sck_out),
    .sdo_out    (sdo_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && req_out) req_cnt++;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic next_rise(output bit ok);
    logic p;
    p  = sck_out;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sck_out && !p) begin
        ok = 1'b1;
        break;
      end
      p = sck_out;
    end
  endtask

  task automatic capture(
    input  int          n,
    output logic [63:0] ws_v,
    output logic [63:0] sdo_v,
    output bit          ok
  );
    ws_v  = '0;
    sdo_v = '0;
    ok    = 1'b1;
    for (int i = 0; i < n; i++) begin
      next_rise(ok);
      if (!ok) return;
      ws_v[63-i]  = ws_out;
      sdo_v[63-i] = sdo_out;
    end
  endtask

  task automatic measure(output int clks, output bit ok);
    time t1;
    bit  ok2;
    clks = 0;
    next_rise(ok);
    t1 = $time;
    next_rise(ok2);
    ok = ok && ok2;
    clks = int'(($time - t1) / 10);
  endtask

  localparam logic [63:0] WS_I2S = {32'h0, 32'hFFFF_FFFF};
  localparam logic [63:0] WS_TDM = {1'b1, 63'h0};
  localparam logic [63:0] SDO_F1 =
    {1'b0, 24'hABCDEF, 8'h0, 24'h123456, 7'h0};
  localparam logic [63:0] SDO_F3 =
    {1'b0, 24'h222222, 8'h0, 24'h333333, 7'h0};
  localparam logic [63:0] SDO_F4 =
    {1'b0, 24'hF0F0F0, 8'h0, 24'h0F0F0F, 7'h0};
  localparam logic [63:0] SDO_TD =
    {1'b0, 24'hFEDCBA, 8'h0, 24'h654321, 7'h0};
`ifdef I2S_TDM_REPEAT_ON_UNDERRUN_EN
  localparam logic [63:0] SDO_F2 = SDO_F1;
`else
  localparam logic [63:0] SDO_F2 = 64'h0;
`endif

  initial begin
    logic [63:0] wv, sv;
    bit          ok;
    int          per;

    rst_n      = 1'b0;
    play_in    = 1'b0;
    tick_in    = 1'b0;
    audio_in   = '0;
    cfg_in     = 1'b0;
    cfg_reg_in = '0;
    repeat (3) @(negedge clk);
    check("rst_sck", sck_out, 0);
    check("rst_ws", ws_out, 0);
    check("rst_sdo", sdo_out, 0);
    check("rst_req", req_out, 0);

    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_req", req_cnt, 0);
    check("idle_sck", sck_out, 0);

    // frame 1: I2S, div 0, tick then play
    cfg_in     = 1'b1;
    cfg_reg_in = 32'h0;
    @(negedge clk);
    cfg_in   = 1'b0;
    tick_in  = 1'b1;
    audio_in = {24'h123456, 24'hABCDEF};
    @(negedge clk);
    tick_in = 1'b0;
    play_in = 1'b1;
    @(negedge clk);
    check("f1_req", req_out, 1);
    check("f1_ws0", ws_out, 0);
    capture(64, wv, sv, ok);
    check("f1_sck_ok", ok, 1);
    check("f1_ws", wv, WS_I2S);
    check("f1_sdo", sv, SDO_F1);

    // frame 2: underrun; two ticks queue data for frame 3
    fork
      capture(64, wv, sv, ok);
      begin
        repeat (20) @(negedge clk);
        tick_in  = 1'b1;
        audio_in = {24'h111111, 24'h111111};
        @(negedge clk);
        audio_in = {24'h333333, 24'h222222};
        @(negedge clk);
        tick_in = 1'b0;
      end
    join
    check("f2_sck_ok", ok, 1);
    check("f2_ws", wv, WS_I2S);
    check("f2_sdo", sv, SDO_F2);
    check("f2_reqs", req_cnt, 2);

    // frame 3: last tick wins; play drops, cfg during drain
    fork
      capture(64, wv, sv, ok);
      begin
        repeat (30) @(negedge clk);
        play_in = 1'b0;
        repeat (10) @(negedge clk);
        cfg_in     = 1'b1;
        cfg_reg_in = 32'h7;
        @(negedge clk);
        cfg_in = 1'b0;
      end
    join
    check("f3_sck_ok", ok, 1);
    check("f3_sdo", sv, SDO_F3);
    check("f3_reqs", req_cnt, 3);
    repeat (20) @(negedge clk);
    check("drain_sck", sck_out, 0);
    check("drain_ws", ws_out, 0);
    check("drain_sdo", sdo_out, 0);
    check("drain_reqs", req_cnt, 3);

    // frame 4: config must still be div 0, I2S
    tick_in  = 1'b1;
    audio_in = {24'h0F0F0F, 24'hF0F0F0};
    @(negedge clk);
    tick_in = 1'b0;
    play_in = 1'b1;
    @(negedge clk);
    check("f4_req", req_out, 1);
    capture(64, wv, sv, ok);
    check("f4_sck_ok", ok, 1);
    check("f4_ws", wv, WS_I2S);
    check("f4_sdo", sv, SDO_F4);
    measure(per, ok);
    check("f4_per_ok", ok, 1);
    check("f4_sck_per", per, 4);
    play_in = 1'b0;
    repeat (400) @(negedge clk);
    check("f5_idle_sck", sck_out, 0);
    check("f5_reqs", req_cnt, 5);

    // TDM, div 1, tick and play in the same cycle
    cfg_in     = 1'b1;
    cfg_reg_in = 32'hA5;
    @(negedge clk);
    cfg_in   = 1'b0;
    tick_in  = 1'b1;
    play_in  = 1'b1;
    audio_in = {24'h654321, 24'hFEDCBA};
    @(negedge clk);
    tick_in = 1'b0;
    check("td_req", req_out, 1);
    capture(64, wv, sv, ok);
    check("td_sck_ok", ok, 1);
    check("td_ws", wv, WS_TDM);
    check("td_sdo", sv, SDO_TD);
    check("td_reqs", req_cnt, 6);
    measure(per, ok);
    check("td_per_ok", ok, 1);
    check("td_sck_per", per, 8);

    // reset in the middle of a frame, while SCK is high
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (sck_out) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mr_sck_hi", ok, 1);
    rst_n   = 1'b0;
    play_in = 1'b0;
    #1;
    check("mr_sck", sck_out, 0);
    check("mr_ws", ws_out, 0);
    check("mr_sdo", sdo_out, 0);
    check("mr_req", req_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mr_reqs", req_cnt, 7);
    check("mr_idle_sck", sck_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_unit.md
I2S_TDM_UNIT -- requirements
Module: i2s_tdm_unit

Interface
REQ-001 Parameter CHANNELS, default 2, SHALL be the slots per frame: even, 2..8.
REQ-002 Parameter SAMPLE_W, default 24, SHALL be the sample width: 16..32.
REQ-003 clk  input  1  master clock (MCLK); the single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 play_in  input  1  level; 1 = stream audio, 0 = stop at the frame boundary.
REQ-006 tick_in  input  1  one-cycle pulse; audio_in is valid.
REQ-007 audio_in  input  CHANNELS*SAMPLE_W  frame samples; channel k occupies bits [(k+1)*SAMPLE_W-1 : k*SAMPLE_W].
REQ-008 cfg_in  input  1  one-cycle pulse; capture cfg_reg_in.
REQ-009 cfg_reg_in  input  32  config word: [1:0] SCK divider select, [2] mode (0 = I2S, 1 = TDM), other bits ignored.
REQ-010 req_out  output  1  one-cycle pulse requesting the next frame.
REQ-011 ws_out, sck_out, sdo_out  output  1 each  serial word-select, bit clock, data.

Function
REQ-012 Frame SHALL be CHANNELS slots of 32 SCK periods; each sample is MSB-first, left-justified, with zero padding.
REQ-013 SCK half-period in clk cycles SHALL be 2, 4, 8 or 16 for divider select 0..3.
REQ-014 FSM states SHALL be IDLE, RUN and DRAIN. IDLE->RUN when play_in=1. RUN->DRAIN when play_in=0. DRAIN->IDLE at the end of the current frame. DRAIN->RUN if play_in returns to 1 before the frame ends.
REQ-015 In IDLE, sck_out, ws_out and sdo_out SHALL be 0, and the SCK counter SHALL be held cleared.
REQ-016 cfg_in SHALL update the config register only in IDLE; in RUN or DRAIN it SHALL be ignored.
REQ-017 A 1-entry holding buffer SHALL capture audio_in on tick_in. A tick while the buffer is full SHALL overwrite it. A tick in IDLE SHALL be captured.
REQ-018 Frame start (first cycle of RUN, and the cycle after the last SCK falling edge of each frame in RUN) SHALL do three things: load the buffer into the shift register, clear the buffer, and pulse req_out for exactly 1 clk.
REQ-019 If the buffer is empty at frame start (underrun), the transmitted frame SHALL be all zeros (see REQ-025).
REQ-020 sck_out SHALL start low in each frame. sdo_out and ws_out SHALL change only on SCK falling edges (clk cycle after sck_out goes 1->0), plus the initial frame-start update.
REQ-021 I2S mode: ws_out SHALL be 0 for slots 0..CHANNELS/2-1 and 1 for the rest. ws_out SHALL change one SCK period before the slot MSB, so sdo lags ws by 1 SCK, including the wrap-around to the next frame.
REQ-022 TDM mode: ws_out SHALL be 1 for exactly one SCK period, the period preceding the slot-0 MSB, and 0 otherwise.
REQ-023 If play_in and tick_in are asserted in the same cycle from IDLE, the tick data SHALL be captured and still be the data transmitted in that first frame.

Reset
REQ-024 While rst_n=0, all outputs, the buffer, the shift register, the counters and the FSM state SHALL be 0 / IDLE. The config register SHALL reset to divider 0, I2S mode. Assertion mid-frame SHALL abort the frame immediately.

Configuration
REQ-025 With I2S_TDM_REPEAT_ON_UNDERRUN_EN defined, an underrun SHALL retransmit the previous frame's samples (all zeros if there is none since reset). Without it, an underrun SHALL transmit zeros.

Structure
REQ-026 audioport_pkg SHALL hold: I2S_SLOT_W=32; the cfg field positions and widths; the FSM state enum type; and the divider-to-half-period table.
REQ-027 A sub-module i2s_sck_gen SHALL generate the SCK and the rise/fall enable strobes from the divider select and a run enable.

Verification
REQ-028 Reset: rst_n=0 mid-frame -> all outputs 0 within 1 clk; after release, IDLE with no req_out.
REQ-029 CHANNELS=2, SAMPLE_W=24, div=0, I2S, tick with ch0=0xABCDEF and ch1=0x123456, play=1 -> req_out pulse; ws=0 for the first 32 SCK, then 1; sdo carries ch0 MSB-first starting 1 SCK after ws falls, followed by 8 zero bits.
REQ-030 CHANNELS=4, TDM, div=1 -> 128 SCK per frame; SCK period 8 clk; ws high for 1 SCK before slot 0 only.
REQ-031 No tick after the first frame -> frame 2 is all zeros; with I2S_TDM_REPEAT_ON_UNDERRUN_EN, frame 2 repeats frame 1.
REQ-032 play dropped mid-frame -> frame completes, then IDLE with outputs 0. A cfg_in pulse during DRAIN -> config unchanged.
REQ-033 Two ticks before frame start (0x111111, then 0x222222) -> 0x222222 transmitted; exactly one req_out per frame.
